// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad time-entry controller for the digital watch.
// Registers the keypad and buttons, qualifies one-hot key presses, range-checks
// each BCD digit against its HH:MM:SS position, and hands the edited time to
// the watch counters with a one-cycle load strobe.
// Optional feature macro: CURSOR_BLINK_EN (blinks the digit under the cursor).
//
// Handshake: there is no valid/ready pair here. load is a one-cycle,
// fire-and-forget strobe. set_time is stable for the whole cycle in which
// load is high, and the counters must capture it on that cycle.
module time_set_ctrl #(
  parameter int TIMEOUT_CYC   = 10000,
  parameter int START_IN_EDIT = 1,
  parameter int BLINK_HALF    = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  key_input,
  input  logic        btn_set,
  input  logic        btn_done,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load,
  output logic        edit_mode,
  output logic [2:0]  cursor,
  output logic        key_err,
  output logic        abort,
  output logic [5:0]  digit_blank,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam state_e RESET_STATE = (START_IN_EDIT != 0) ? ST_EDIT : ST_RUN;
  // The timeout counter only has to reach TIMEOUT_CYC-1, where it saturates.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e      state_q, state_d;
  logic [9:0]  key_q, key_d, key_prev_q, key_prev_d;
  logic        set_q, set_d, set_prev_q, set_prev_d;
  logic        done_q, done_d, done_prev_q, done_prev_d;
  logic [23:0] set_time_q, set_time_d;
  logic [2:0]  cursor_q, cursor_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        key_err_q, key_err_d, abort_q, abort_d;

  logic        key_accept, set_edge, done_edge, timeout_hit;
  logic        in_edit, key_write, key_write_ok, snapshot;
  logic [3:0]  key_digit, digit_max;

  // Input stage: one register per pin plus the previous registered value.
  always_comb begin
    key_d       = key_input;
    key_prev_d  = key_q;
    set_d       = btn_set;
    set_prev_d  = set_q;
    done_d      = btn_done;
    done_prev_d = done_q;
  end

  // Press qualification: exactly one key, arriving after an all-released vector.
  always_comb begin
    key_accept = (key_q != 10'd0) && ((key_q & (key_q - 10'd1)) == 10'd0) &&
                 (key_prev_q == 10'd0);
    set_edge   = set_q & ~set_prev_q;
    done_edge  = done_q & ~done_prev_q;
    key_digit  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_q[i]) key_digit = 4'(i);
    end
  end

  // Largest legal digit for the position under the cursor.
  always_comb begin
    case (cursor_q)
      3'd0:       digit_max = 4'd2;
      3'd1:       digit_max = (set_time_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4: digit_max = 4'd5;
      default:    digit_max = 4'd9;
    endcase
  end

  // Event decode; btn_done outranks both the timeout and a same-cycle key.
  always_comb begin
    in_edit      = (state_q == ST_EDIT);
    timeout_hit  = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST);
    key_write    = in_edit && key_accept && !done_edge && !timeout_hit;
    key_write_ok = key_write && (key_digit <= digit_max);
    key_err_d    = key_write && (key_digit > digit_max);
    abort_d      = in_edit && !done_edge && timeout_hit;
    snapshot     = (state_q == ST_RUN) && set_edge;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (set_edge) state_d = ST_EDIT;
      ST_EDIT: begin
        if (done_edge)        state_d = ST_COMMIT;
        else if (timeout_hit) state_d = ST_RUN;
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Edit buffer, cursor and saturating timeout counter.
  always_comb begin
    set_time_d = set_time_q;
    cursor_d   = cursor_q;
    to_cnt_d   = to_cnt_q;
    if (snapshot) begin
      set_time_d = cur_time;
      cursor_d   = 3'd0;
      to_cnt_d   = '0;
    end else if (in_edit) begin
      if (key_write_ok) begin
        case (cursor_q)
          3'd0: begin
            set_time_d[23:20] = key_digit;
            // 2x hours cannot keep an hour digit above 3.
            if (key_digit == 4'd2 && set_time_q[19:16] > 4'd3) set_time_d[19:16] = 4'd0;
          end
          3'd1:    set_time_d[19:16] = key_digit;
          3'd2:    set_time_d[15:12] = key_digit;
          3'd3:    set_time_d[11:8]  = key_digit;
          3'd4:    set_time_d[7:4]   = key_digit;
          default: set_time_d[3:0]   = key_digit;
        endcase
        cursor_d = (cursor_q >= 3'd5) ? 3'd0 : cursor_q + 3'd1;
        to_cnt_d = '0;
      end else if ((TIMEOUT_CYC != 0) && (to_cnt_q != TO_LAST)) begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      key_q       <= '0;
      key_prev_q  <= '0;
      set_q       <= 1'b0;
      set_prev_q  <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
      set_time_q  <= '0;
      cursor_q    <= '0;
      to_cnt_q    <= '0;
      key_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_prev_q  <= key_prev_d;
      set_q       <= set_d;
      set_prev_q  <= set_prev_d;
      done_q      <= done_d;
      done_prev_q <= done_prev_d;
      set_time_q  <= set_time_d;
      cursor_q    <= cursor_d;
      to_cnt_q    <= to_cnt_d;
      key_err_q   <= key_err_d;
      abort_q     <= abort_d;
    end
  end

  // FSM outputs are decoded straight from the state register.
  always_comb begin
    load      = (state_q == ST_COMMIT);
    edit_mode = (state_q != ST_RUN);
    dbg_state = state_q;
    set_time  = set_time_q;
    cursor    = cursor_q;
    key_err   = key_err_q;
    abort     = abort_q;
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Blink phase restarts unblanked on EDIT entry and on every cursor move.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!in_edit || key_write_ok) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  // Blink counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // Blank only the digit under the cursor during the off half of the blink.
  always_comb begin
    digit_blank = '0;
    if (in_edit && blink_ph_q) digit_blank = 6'(6'b1 << cursor_q);
  end
`else
  // Without blinking every digit stays lit.
  always_comb begin
    digit_blank = '0;
  end
`endif

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Controller that sequences keypad time entry for the digital watch. It owns the edit-mode state machine, edge-qualifies 10-key one-hot keypad input, range-checks each BCD digit, and tracks the cursor over six digits (HH:MM:SS). It commits the edited time to the watch counters through a one-cycle load strobe. It sits between the keypad/buttons and the watch counter/display blocks, all in the 1 kHz clk domain.

Parameters:
TIMEOUT_CYC, 10000, cycles in EDIT without an accepted key before the edit is aborted (10 s at 1 kHz); 0 disables the timeout
START_IN_EDIT, 1, 1 = leave reset directly into EDIT with a zero buffer; 0 = leave reset into RUN
BLINK_HALF, 250, half-period in cycles of the cursor blink (used only with CURSOR_BLINK_EN)

Ports:
clk  in  1  system clock, 1 kHz
rst  in  1  reset; synchronous, active-low
key_input  in  10  keypad; bit n high = key n pressed
btn_set  in  1  enter edit mode
btn_done  in  1  commit edit
cur_time  in  24  live time from counters, BCD {h_ten,h_one,m_ten,m_one,s_ten,s_one}, 4 bits each
set_time  out  24  edit buffer, same packing
load  out  1  one-cycle strobe; counters take set_time
edit_mode  out  1  high in EDIT and COMMIT
cursor  out  3  digit under edit, 0 = h_ten … 5 = s_one
key_err  out  1  one-cycle pulse on a rejected digit
abort  out  1  one-cycle pulse on a timeout abort
digit_blank  out  6  bit i high = blank display digit i

Behaviour:
- Reset (rst==0 at a clk edge): set_time=0, load=0, key_err=0, abort=0, cursor=0, digit_blank=0, and the timeout and blink counters clear.
- On reset, state=EDIT (edit_mode=1) if START_IN_EDIT=1, else state=RUN (edit_mode=0).
- Reset asserted mid-edit discards the buffer and never asserts load.
- Input qualification:
  - key_input, btn_set and btn_done are each registered once.
  - A key press is accepted only on the cycle where the registered key vector is exactly one-hot and the previous registered vector was all-zero.
  - Multi-hot vectors are ignored. A held key counts as one press.
  - Buttons act on their rising edge (registered 0→1).
  - Latency from pin to buffer update is 2 cycles.
- FSM states:
  - RUN: keys ignored. A btn_set edge snapshots cur_time into set_time, sets cursor=0, clears the timeout counter, and moves to EDIT.
  - EDIT: accepted keys write the digit at cursor (rules below). A btn_done edge moves to COMMIT. Timeout expiry moves to RUN with abort=1 for one cycle and load=0. btn_set in EDIT is ignored.
  - COMMIT: load=1 for exactly one cycle with set_time stable, then RUN.
- Digit limits by cursor position:
  - 0: value ≤2.
  - 1: value ≤9, or ≤3 when buffer h_ten==2.
  - 2 and 4: value ≤5.
  - 3 and 5: value ≤9.
- Valid digit: write the digit into the buffer, advance cursor, clear the timeout counter. The cursor wraps 5→0.
- Writing h_ten=2 while buffer h_one>3 also forces h_one=0 in the same cycle.
- Invalid digit: buffer and cursor unchanged, key_err=1 for one cycle, timeout counter not cleared.
- Simultaneous btn_done edge and accepted key: btn_done wins, and the key is dropped.
- Timeout counter saturates and never wraps. Expiry occurs when the count reaches TIMEOUT_CYC-1.
- set_time holds its value in RUN, so it keeps the last committed or aborted buffer.

Optional Feature:
CURSOR_BLINK_EN
- Defined: in EDIT, digit_blank[cursor] toggles every BLINK_HALF cycles, starting unblanked on EDIT entry; all other bits are 0. The blink phase restarts on every cursor move. digit_blank=0 in RUN and COMMIT.
- Undefined: digit_blank is tied to 0, and the blink counter is not built.

Test Plan:
- Reset with START_IN_EDIT=1 → edit_mode=1, cursor=0, set_time=0; keys 1,2,3,4,5,6 (each one-hot, released between presses), then btn_done → set_time=0x123456, load high for exactly 1 cycle, edit_mode=0 next cycle.
- In EDIT at cursor 0, press key 3 → key_err pulse, cursor stays 0; press 2 then 7 → key_err on the 7, cursor stays 1; press 3 → set_time[23:16]=0x23, cursor=2.
- Buffer 0x150000, cursor 0, press 2 → set_time=0x200000 (h_one forced to 0), cursor=1.
- Hold key 5 for 50 cycles → exactly one digit written; drive key_input=0x003 → ignored, no key_err.
- RUN with cur_time=0x084512, btn_set → set_time=0x084512; idle TIMEOUT_CYC cycles → abort pulse, load never asserted, edit_mode=0.
- btn_done edge coincident with a key press → load asserted with the buffer unchanged; rst low during EDIT → no load, state per START_IN_EDIT.
